div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle sequencer for the 32-bit DIV/DIVU datapath in the EX stage.
- Accepts operands from EX and runs a radix-2 restoring division, one quotient bit per cycle.
- Returns {remainder, quotient} as a 64-bit HI/LO result with a ready handshake.
- While it is busy, EX raises stallreq toward ctrl, the same way the MADD/MSUB multi-cycle path does.

Parameters:
- DW, 32, operand width. The result is 2*DW wide and the iteration count is DW.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DW  dividend.
- opdata2_i  in  DW  divisor.
- start_i  in  1  request from EX; held high until the result is consumed.
- annul_i  in  1  cancel an in-flight division (pipeline flush).
- result_o  out  2*DW  {remainder[DW-1:0], quotient[DW-1:0]}, registered.
- ready_o  out  1  result valid, registered.

Behaviour:
- Reset (rst=0, any time, including mid-division):
  - state=FREE, cnt=0, working regs=0, result_o=0, ready_o=0.
  - Takes effect immediately (asynchronous).
- States: FREE, BYZERO, ON, END.
- FREE:
  - ready_o=0, result_o=0.
  - start_i=1 & annul_i=0 & opdata2_i==0 → BYZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 → ON.
  - On the ON transition, latch |dividend| and |divisor|:
    - Absolute values are taken only if signed_div_i=1 and the operand MSB=1.
    - Also latch signed_div_i, the quotient sign (dividend MSB xor divisor MSB) and the remainder sign (dividend MSB).
    - Set cnt=0 and partial remainder=0.
  - start_i=1 with annul_i=1 is ignored.
- BYZERO: on the next edge → END with result_o=0 and ready_o=1.
- ON, annul_i=1: → FREE on the next edge, with outputs kept at 0 and no result produced.
- ON, annul_i=0, cnt<DW, one iteration per edge:
  - Form the trial value {partial_rem, next dividend bit} minus the divisor, computed DW+1 bits wide.
  - If the result is non-negative, the quotient bit is 1 and the trial value becomes the new partial remainder. Otherwise the quotient bit is 0 and the partial remainder is {partial_rem, bit}.
  - cnt increments.
- ON, cnt==DW: on the next edge → END.
  - Apply sign correction when signed: the quotient is negated if its sign bit is set; the remainder is negated if the dividend was negative.
  - Write result_o and set ready_o=1.
- Latency: start sampled at edge 0 → ready_o=1 visible after edge DW+1 (33 for DW=32). Divide-by-zero: ready_o after edge 1.
- END:
  - Hold result_o and ready_o while start_i=1, regardless of operand changes.
  - start_i=0 → FREE on the next edge, clearing ready_o and result_o.
  - annul_i has no effect in END.
  - A new start requires at least one FREE cycle. Back-to-back: start_i low for 1 cycle, then high.
- Operand changes on opdata*_i or signed_div_i after start is accepted are ignored; only the latched values are used.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0. This falls out of the magnitude arithmetic with no special case.
- Remainder sign always follows the dividend, and |remainder| < |divisor|.
- EX integration:
  - stallreq_from_ex is asserted while start_i=1 & ready_o=0.
  - EX drops start_i in the cycle after it samples ready_o=1.
  - EX drives annul_i from the flush signal.

Test Plan:
- DIVU 100/7: start_i=1 for 34 cycles → ready_o rises exactly 33 edges after acceptance, result_o=0x00000002_0000000E, held until start_i=0, then 0 one cycle later.
- DIV −7/2 (0xFFFFFFF9, 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD. DIV 7/−2 → 0x00000001_FFFFFFFD. DIVU 0xFFFFFFF9/2 → 0x00000001_7FFFFFFC.
- Divide by zero (any dividend, opdata2_i=0) → ready_o=1 after 1 edge, result_o=0. Signed overflow 0x80000000/0xFFFFFFFF → 0x00000000_80000000.
- annul_i pulsed at iteration 10 → state FREE next edge, ready_o never rises. An immediate new start 50/5 → 0x00000000_0000000A after 33 edges. annul_i together with start_i in FREE → no acceptance.
- rst driven low asynchronously mid-iteration (between edges) → ready_o=0 and result_o=0 immediately. After release, a fresh DIVU 9/3 → 0x00000000_00000003.
- Operand inputs randomised every cycle after acceptance → result matches the latched operands. Random regression of 10k signed/unsigned pairs against a reference model.

Source files
------------

// File: rtl/div_seq_if.sv
// EX <-> divider handshake bundle: operands and control from EX, HI/LO result back.
interface div_seq_if #(
  parameter int unsigned DW = 32
);
  logic            signed_div_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic            start_i;
  logic            annul_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;

  // EX stage side
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  // Divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient}; one quotient bit per cycle, DW iterations.
module div_seq #(
  parameter int unsigned DW = 32
) (
  input logic     clk,
  input logic     rst,
  div_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   dvd_q;     // remaining dividend bits, quotient bits shift in at the LSB
  logic [DW-1:0]   dvs_q;     // |divisor|
  logic [DW-1:0]   rem_q;     // partial remainder
  logic            sd_q;
  logic            q_sign_q;
  logic            r_sign_q;
  logic [2*DW-1:0] result_q;
  logic            ready_q;

  logic [DW-1:0]   abs1;
  logic [DW-1:0]   abs2;
  logic [DW:0]     trial_in;
  logic [DW:0]     diff;
  logic            qbit;
  logic [DW-1:0]   rem_next;
  logic [DW-1:0]   quo_fix;
  logic [DW-1:0]   rem_fix;

  // Operand magnitudes; only signed divides with a negative operand are negated
  always_comb begin
    abs1 = bus.opdata1_i;
    abs2 = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[DW-1]) abs1 = '0 - bus.opdata1_i;
    if (bus.signed_div_i && bus.opdata2_i[DW-1]) abs2 = '0 - bus.opdata2_i;
  end

  // One restoring step: the partial remainder stays below the divisor, so the
  // DW+1-bit difference has a valid sign bit and a non-negative result fits DW bits
  always_comb begin
    trial_in = {rem_q, dvd_q[DW-1]};
    diff     = trial_in - {1'b0, dvs_q};
    qbit     = ~diff[DW];
    rem_next = qbit ? diff[DW-1:0] : trial_in[DW-1:0];
  end

  // Sign correction of the finished magnitudes
  always_comb begin
    quo_fix = (sd_q && q_sign_q) ? ('0 - dvd_q) : dvd_q;
    rem_fix = (sd_q && r_sign_q) ? ('0 - rem_q) : rem_q;
  end

  // Sequencer FSM with registered result/ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FREE;
      cnt      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sd_q     <= 1'b0;
      q_sign_q <= 1'b0;
      r_sign_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        ST_FREE: begin
          result_q <= '0;
          ready_q  <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= ST_BYZERO;
            end else begin
              state    <= ST_ON;
              dvd_q    <= abs1;
              dvs_q    <= abs2;
              rem_q    <= '0;
              cnt      <= '0;
              sd_q     <= bus.signed_div_i;
              q_sign_q <= bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1];
              r_sign_q <= bus.opdata1_i[DW-1];
            end
          end
        end
        ST_BYZERO: begin
          state    <= ST_END;
          result_q <= '0;
          ready_q  <= 1'b1;
        end
        ST_ON: begin
          if (bus.annul_i) begin
            state    <= ST_FREE;
            result_q <= '0;
            ready_q  <= 1'b0;
          end else if (cnt != CW'(DW)) begin
            dvd_q <= {dvd_q[DW-2:0], qbit};
            rem_q <= rem_next;
            cnt   <= cnt + 1'b1;
          end else begin
            state    <= ST_END;
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
          end
        end
        ST_END: begin
          if (!bus.start_i) begin
            state    <= ST_FREE;
            result_q <= '0;
            ready_q  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_FREE;
          result_q <= '0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus a randomized regression
// against an arithmetic reference model.
module tb_div_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  div_seq_if #(.DW(32)) bus ();

  div_seq #(.DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer division, remainder sign follows the dividend
  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sd) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic scramble_ops();
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = 1'($urandom_range(0, 1));
  endtask

  // Wait for ready; lat counts edges from the acceptance edge (0). 40 means timeout.
  task automatic wait_ready(input bit scr, output logic [63:0] res, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ready_o === 1'b1) break;
      if (scr) scramble_ops();
    end
    if (bus.ready_o !== 1'b1) lat = 40;
    res = bus.result_o;
  endtask

  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input bit scr, output logic [63:0] res, output int lat);
    @(negedge clk);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    wait_ready(scr, res, lat);
  endtask

  task automatic drop_start();
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++;
    if (bus.ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.ready_o); end
    n_cmp++;
    if (bus.result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_divu_basic();
    logic [63:0] res;
    int lat;
    do_div(1'b0, 32'd100, 32'd7, 1'b0, res, lat);
    n_cmp++;
    if (lat !== 33) begin n_bad++; $display("FAIL divu_latency: got %0d want 33", lat); end
    n_cmp++;
    if (res !== 64'h00000002_0000000E) begin n_bad++; $display("FAIL divu_result: got %h want 000000020000000e", res); end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) begin
      n_bad++; $display("FAIL divu_hold: got ready=%b res=%h want ready=1 res=000000020000000e", bus.ready_o, bus.result_o);
    end
    drop_start();
    n_cmp++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_bad++; $display("FAIL divu_clear: got ready=%b res=%h want 0/0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_signed_cases();
    logic        sd_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] a_t   [4] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] b_t   [4] = '{32'h00000002, 32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFF};
    logic [63:0] exp_t [4] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                               64'h00000001_7FFFFFFC, 64'h00000000_80000000};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_div(sd_t[i], a_t[i], b_t[i], 1'b0, res, lat);
      n_cmp++;
      if (res !== exp_t[i] || lat !== 33) begin
        n_bad++; $display("FAIL signed_case%0d: got %h lat %0d want %h lat 33", i, res, lat, exp_t[i]);
      end
      drop_start();
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] a_t [3] = '{32'd0, 32'h12345678, 32'hFFFFFFFF};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_div(1'(i % 2), a_t[i], 32'd0, 1'b0, res, lat);
      n_cmp++;
      if (lat !== 1 || res !== 64'd0) begin
        n_bad++; $display("FAIL div_zero%0d: got %h lat %0d want 0 lat 1", i, res, lat);
      end
      drop_start();
    end
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int lat;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_bad++; $display("FAIL annul_outputs: got ready=%b res=%h want 0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    bus.annul_i   = 1'b0;
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    wait_ready(1'b0, res, lat);
    n_cmp++;
    if (lat !== 33 || res !== 64'h0000000A) begin
      n_bad++; $display("FAIL annul_restart: got %h lat %0d want 000000000000000a lat 33", res, lat);
    end
    drop_start();
  endtask

  task automatic test_annul_in_free();
    logic [63:0] res;
    int lat;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd20;
    bus.opdata2_i    = 32'd4;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    // Edge 0 of the wait is the first edge that may legally accept
    wait_ready(1'b0, res, lat);
    n_cmp++;
    if (lat !== 33 || res !== 64'd5) begin
      n_bad++; $display("FAIL annul_free: got %h lat %0d want 0000000000000005 lat 33", res, lat);
    end
    drop_start();
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int lat;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd77;
    bus.opdata2_i    = 32'd6;
    bus.start_i      = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_bad++; $display("FAIL async_rst_mid: got ready=%b res=%h want 0/0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div(1'b0, 32'd100, 32'd7, 1'b0, res, lat);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_bad++; $display("FAIL async_rst_end: got ready=%b res=%h want 0/0", bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div(1'b0, 32'd9, 32'd3, 1'b0, res, lat);
    n_cmp++;
    if (lat !== 33 || res !== 64'd3) begin
      n_bad++; $display("FAIL async_rst_after: got %h lat %0d want 0000000000000003 lat 33", res, lat);
    end
    drop_start();
  endtask

  task automatic test_operand_scramble();
    logic        sd;
    logic [31:0] a, b;
    logic [63:0] res, exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      sd  = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = (i == 0) ? 32'd0 : $urandom_range(1, 200000);
      exp = ref_div(sd, a, b);
      do_div(sd, a, b, 1'b1, res, lat);
      n_cmp++;
      if (res !== exp) begin
        n_bad++; $display("FAIL scramble%0d: got %h want %h", i, res, exp);
      end
      repeat (2) begin
        scramble_ops();
        bus.annul_i = 1'b1;
        @(posedge clk); #1;
      end
      n_cmp++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
        n_bad++; $display("FAIL end_hold%0d: got ready=%b res=%h want 1 %h", i, bus.ready_o, bus.result_o, exp);
      end
      drop_start();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat;
    for (int i = 1; i <= 3; i++) begin
      do_div(1'b0, 32'(i * 1000 + 7), 32'(i + 2), 1'b0, res, lat);
      n_cmp++;
      if (lat !== 33 || res !== ref_div(1'b0, 32'(i * 1000 + 7), 32'(i + 2))) begin
        n_bad++; $display("FAIL back_to_back%0d: got %h lat %0d want %h lat 33", i, res, lat,
                          ref_div(1'b0, 32'(i * 1000 + 7), 32'(i + 2)));
      end
      drop_start();
    end
  endtask

  task automatic test_random();
    logic        sd;
    logic [31:0] a, b;
    logic [63:0] res, exp;
    int lat, exp_lat;
    for (int i = 0; i < 300; i++) begin
      sd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = '0 - 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 100);
        default: a = $urandom;
      endcase
      exp     = ref_div(sd, a, b);
      exp_lat = (b == 32'd0) ? 1 : 33;
      do_div(sd, a, b, 1'($urandom_range(0, 1)), res, lat);
      n_cmp++;
      if (res !== exp || lat !== exp_lat) begin
        n_bad++; $display("FAIL random%0d sd=%b a=%h b=%h: got %h lat %0d want %h lat %0d",
                          i, sd, a, b, res, lat, exp, exp_lat);
      end
      drop_start();
    end
  endtask

  initial begin
    n_cmp            = 0;
    n_bad            = 0;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    test_reset();
    test_divu_basic();
    test_signed_cases();
    test_div_zero();
    test_annul();
    test_annul_in_free();
    test_async_reset();
    test_operand_scramble();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
